// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, operation codes and arbiter state encoding.
// Imported by the shared ALU and by the arbiter that fronts it.
package alu_pkg;

  localparam int XLEN = 32;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'd0;
  localparam alu_op_t ALU_SUB  = 4'd1;
  localparam alu_op_t ALU_AND  = 4'd2;
  localparam alu_op_t ALU_OR   = 4'd3;
  localparam alu_op_t ALU_XOR  = 4'd4;
  localparam alu_op_t ALU_SLL  = 4'd5;
  localparam alu_op_t ALU_SRL  = 4'd6;
  localparam alu_op_t ALU_SRA  = 4'd7;
  localparam alu_op_t ALU_SLT  = 4'd8;
  localparam alu_op_t ALU_SLTU = 4'd9;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purpose: 32-bit combinational ALU; unused opcodes yield zero.
// Latency: none (purely combinational).
// Backpressure: none; the caller registers the result.
module alu_share_arbiter_alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      ALUOp,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  logic [4:0] shamt;

  assign shamt = B[4:0];

  always_comb begin
    Result = '0;
    case (ALUOp)
      ALU_ADD:  Result = A + B;
      ALU_SUB:  Result = A - B;
      ALU_AND:  Result = A & B;
      ALU_OR:   Result = A | B;
      ALU_XOR:  Result = A ^ B;
      ALU_SLL:  Result = A << shamt;
      ALU_SRL:  Result = A >> shamt;
      ALU_SRA:  Result = $signed(A) >>> shamt;
      ALU_SLT:  Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: Result = {{(XLEN-1){1'b0}}, (A < B)};
      default:  Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one ALU among NREQ requesters; registered result to the winner.
// Latency: handshake at edge N -> rsp_valid/rsp_result visible right after edge N.
// Backpressure: no grant while the held result is unconsumed; consume and reload in one edge.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*4-1:0]    req_op,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 rsp_zero,
  output logic                 busy
);

  localparam int IDXW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] own_q;
  logic [IDXW-1:0] rr_ptr_q;
  logic [IDXW-1:0] gnt_idx;
  logic [IDXW-1:0] rr_ptr_next;
  logic [NREQ-1:0] gnt_oh;
  logic [NREQ-1:0] rsp_valid_q;
  logic [XLEN-1:0] rsp_result_q;
  logic            rsp_zero_q;
  logic            can_accept;
  logic            grant;
  logic            consume;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [3:0]      alu_op;
  logic            alu_zero;

  // Rotate requests right by ptr, take lowest set bit, rotate the pick back left.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [IDXW-1:0] ptr);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   pick;
    dbl  = {valid, valid} >> ptr;
    rot  = dbl[NREQ-1:0];
    pick = rot & (~rot + ONE);
    dbl  = {pick, pick} << ptr;
    return dbl[2*NREQ-1:NREQ];
  endfunction

  assign busy       = (state_q == ST_FULL);
  assign consume    = busy && rsp_ready[own_q];
  assign can_accept = !busy || rsp_ready[own_q];
  assign gnt_oh     = rr_pick(req_valid, rr_ptr_q);
  assign req_ready  = (can_accept && !rst) ? gnt_oh : '0;
  assign grant      = |req_ready;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) gnt_idx = IDXW'(i);
    end
  end

  assign rr_ptr_next = (gnt_idx == IDXW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  assign alu_a  = req_a[XLEN*gnt_idx +: XLEN];
  assign alu_b  = req_b[XLEN*gnt_idx +: XLEN];
  assign alu_op = req_op[4*gnt_idx +: 4];

  alu_share_arbiter_alu u_alu (
    .A      (alu_a),
    .B      (alu_b),
    .ALUOp  (alu_op),
    .Result (alu_result),
    .Zero   (alu_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL:  if (consume && !grant) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      own_q        <= '0;
      rr_ptr_q     <= '0;
    end else if (grant) begin
      rsp_valid_q  <= gnt_oh;
      rsp_result_q <= alu_result;
      rsp_zero_q   <= alu_zero;
      own_q        <= gnt_idx;
      rr_ptr_q     <= rr_ptr_next;
    end else if (consume) begin
      rsp_valid_q  <= '0;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a 2-requester instance for ops, contention,
// back-pressure and reset, and a 3-requester instance for pointer wrap.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  r2_valid, r2_ready, r2_rvalid, r2_rready;
  logic [63:0] r2_a, r2_b;
  logic [7:0]  r2_op;
  logic [31:0] r2_result;
  logic        r2_zero, r2_busy;

  logic [2:0]  r3_valid, r3_ready, r3_rvalid, r3_rready;
  logic [95:0] r3_a, r3_b;
  logic [11:0] r3_op;
  logic [31:0] r3_result;
  logic        r3_zero, r3_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_a(r2_a), .req_b(r2_b), .req_op(r2_op), .rsp_valid(r2_rvalid),
    .rsp_ready(r2_rready), .rsp_result(r2_result), .rsp_zero(r2_zero), .busy(r2_busy)
  );

  alu_share_arbiter #(.NREQ(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_a(r3_a), .req_b(r3_b), .req_op(r3_op), .rsp_valid(r3_rvalid),
    .rsp_ready(r3_rready), .rsp_result(r3_result), .rsp_zero(r3_zero), .busy(r3_busy)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0]  = '{"add",      4'd0,  32'h0000_0007, 32'h0000_0001, 32'h0000_0008, 1'b0};
    vecs[1]  = '{"add_wrap", 4'd0,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[2]  = '{"sub_neg",  4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{"and",      4'd2,  32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0};
    vecs[4]  = '{"or",       4'd3,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0};
    vecs[5]  = '{"xor",      4'd4,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0};
    vecs[6]  = '{"sll_b21",  4'd5,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0};
    vecs[7]  = '{"srl",      4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0};
    vecs[8]  = '{"sra",      4'd7,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{"slt",      4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1 ^ 1'b1};
    vecs[10] = '{"sltu",     4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[11] = '{"op15",     4'd15, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1};

    r2_valid = '0; r2_rready = '0; r2_a = '0; r2_b = '0; r2_op = '0;
    r3_valid = '0; r3_rready = '0; r3_a = '0; r3_b = '0; r3_op = '0;

    // Reset state
    #1;
    check("rst_req_ready", {30'd0, r2_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, r2_rvalid}, 32'd0);
    check("rst_result", r2_result, 32'd0);
    check("rst_busy", {31'd0, r2_busy}, 32'd0);
    do_reset();

    // 1: single request, held under back-pressure
    r2_valid = 2'b01; r2_a[31:0] = 32'd5; r2_b[31:0] = 32'd3; r2_op[3:0] = 4'd1; r2_rready = 2'b00;
    #1;
    check("t1_req_ready", {30'd0, r2_ready}, 32'h1);
    tick();
    r2_valid = 2'b00;
    check("t1_rsp_valid", {30'd0, r2_rvalid}, 32'h1);
    check("t1_result", r2_result, 32'd2);
    check("t1_zero", {31'd0, r2_zero}, 32'd0);
    check("t1_busy", {31'd0, r2_busy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_hold_result", r2_result, 32'd2);
      check("t1_hold_valid", {30'd0, r2_rvalid}, 32'h1);
    end
    r2_rready = 2'b01;
    tick();
    check("t1_drain_busy", {31'd0, r2_busy}, 32'd0);
    check("t1_drain_valid", {30'd0, r2_rvalid}, 32'd0);

    // 2: contention, alternating grants
    do_reset();
    r2_a = {32'h0000_00F0, 32'd7}; r2_b = {32'h0000_000F, 32'd1}; r2_op = {4'd2, 4'd0};
    r2_valid = 2'b11; r2_rready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_req_ready", {30'd0, r2_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check("t2_rsp_valid", {30'd0, r2_rvalid}, (k % 2 == 0) ? 32'h1 : 32'h2);
      check("t2_result", r2_result, (k % 2 == 0) ? 32'd8 : 32'd0);
      check("t2_zero", {31'd0, r2_zero}, (k % 2 == 0) ? 32'd0 : 32'd1);
    end
    r2_valid = 2'b00;

    // 3: back-pressure then same-cycle consume and reload
    do_reset();
    r2_rready = 2'b00; r2_valid = 2'b10;
    #1;
    check("t3_req1_ready", {30'd0, r2_ready}, 32'h2);
    tick();
    r2_valid = 2'b01;
    #1;
    check("t3_blocked", {30'd0, r2_ready}, 32'h0);
    tick();
    check("t3_still_own1", {30'd0, r2_rvalid}, 32'h2);
    r2_rready = 2'b10;
    #1;
    check("t3_swap_ready", {30'd0, r2_ready}, 32'h1);
    tick();
    check("t3_new_owner", {30'd0, r2_rvalid}, 32'h1);
    check("t3_new_result", r2_result, 32'd8);
    r2_valid = 2'b00;

    // 4: op table, back-to-back on requester 0
    do_reset();
    r2_rready = 2'b01;
    for (int i = 0; i < 12; i++) begin
      r2_valid = 2'b01; r2_op[3:0] = vecs[i].op; r2_a[31:0] = vecs[i].a; r2_b[31:0] = vecs[i].b;
      #1;
      check({vecs[i].name, "_ready"}, {30'd0, r2_ready}, 32'h1);
      tick();
      check({vecs[i].name, "_result"}, r2_result, vecs[i].exp_result);
      check({vecs[i].name, "_zero"}, {31'd0, r2_zero}, {31'd0, vecs[i].exp_zero});
    end
    r2_valid = 2'b00;
    tick();

    // 5: async reset while holding a result
    r2_valid = 2'b01; r2_rready = 2'b00; r2_op[3:0] = 4'd0; r2_a[31:0] = 32'd2; r2_b[31:0] = 32'd2;
    tick();
    check("t5_full", {31'd0, r2_busy}, 32'd1);
    r2_valid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    check("t5_rsp_valid", {30'd0, r2_rvalid}, 32'd0);
    check("t5_result", r2_result, 32'd0);
    check("t5_busy", {31'd0, r2_busy}, 32'd0);
    check("t5_ready_in_rst", {30'd0, r2_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t5_first_grant", {30'd0, r2_ready}, 32'h1);
    r2_valid = 2'b00;

    // 6: three requesters, only 0 and 2 valid -> pointer wraps 2 -> 0
    do_reset();
    r3_a = {32'd4, 32'd0, 32'd1}; r3_b = {32'd8, 32'd0, 32'd1}; r3_op = {4'd3, 4'd0, 4'd0};
    r3_valid = 3'b101; r3_rready = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t6_req_ready", {29'd0, r3_ready}, (k % 2 == 0) ? 32'h1 : 32'h4);
      tick();
      check("t6_rsp_valid", {29'd0, r3_rvalid}, (k % 2 == 0) ? 32'h1 : 32'h4);
      check("t6_result", r3_result, (k % 2 == 0) ? 32'd2 : 32'hC);
    end
    r3_valid = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
